// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory-side responder for the execute-stage data request interface.
//   Requests are accepted into an in-order outstanding queue. Each one is
//   serviced against an internal word-addressed RAM after LATENCY cycles at
//   the queue head. Each request returns exactly one data_ok pulse.
//
// Parameters
//   ADDR_W  : word-index bits; RAM holds 2^ADDR_W 32-bit words (ADDR_W < 30)
//   DEPTH   : maximum accepted-but-unanswered requests (power of 2, >= 2)
//   LATENCY : service cycles per request once it reaches the head (>= 1)
//
// Ports
//   clk, resetn        : clock, synchronous active-low reset
//   data_req           : request valid
//   data_wr            : 1 = write, 0 = read
//   data_wstrb         : byte write enables (writes only)
//   data_addr          : byte address; bits [ADDR_W+1:2] select the word
//   data_size          : access size code, carried along but not used
//   data_wdata         : write data, byte lanes already positioned
//   data_addr_ok       : request accepted when data_req && data_addr_ok
//   data_data_ok       : one-cycle response pulse per accepted request
//   data_rdata         : read word (zero on write responses), held otherwise
//   data_resp_wr       : response belongs to a write
module dmem_responder #(
    parameter int ADDR_W  = 12,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [2:0]  data_size,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        data_resp_wr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state;
    logic [LAT_W-1:0]   lat_cnt;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;

    // Queue storage, one array per request field
    logic               q_wr    [DEPTH];
    logic [3:0]         q_wstrb [DEPTH];
    logic [ADDR_W-1:0]  q_idx   [DEPTH];
    logic [2:0]         q_size  [DEPTH];
    logic [31:0]        q_wdata [DEPTH];

    // Request currently in service
    logic               svc_wr;
    logic [3:0]         svc_wstrb;
    logic [ADDR_W-1:0]  svc_idx;
    logic [2:0]         svc_size;
    logic [31:0]        svc_wdata;

    // Head of queue as seen by the engine
    logic               head_wr;
    logic [3:0]         head_wstrb;
    logic [ADDR_W-1:0]  head_idx;
    logic [2:0]         head_size;
    logic [31:0]        head_wdata;

    logic [31:0]        mem [2**ADDR_W];

    logic               push;
    logic               pop;
    logic               complete;
    logic               mem_we;
    logic [ADDR_W-1:0]  in_idx;

    // Size code and the aliased address bits are intentionally ignored
    logic               unused_ok;
    assign unused_ok = &{1'b0, data_addr[31:ADDR_W+2], data_addr[1:0], svc_size};

    assign in_idx       = data_addr[ADDR_W+1:2];
    assign data_addr_ok = resetn && (count < CNT_FULL);
    assign push         = data_req && data_addr_ok;
    assign complete     = (state == BUSY) && (lat_cnt == '0);

    // IDLE only looks at registered occupancy; a completing engine also
    // takes a request that arrives on the same edge into an empty queue.
    assign pop = ((state == IDLE) && (count != '0)) ||
                 (complete && ((count != '0) || push));

    assign count_next = count + CNT_W'(push) - CNT_W'(pop);
    assign mem_we     = resetn && complete && svc_wr;

    // With an empty queue the only poppable entry is the one being pushed
    always_comb begin
        head_wr    = q_wr[rd_ptr];
        head_wstrb = q_wstrb[rd_ptr];
        head_idx   = q_idx[rd_ptr];
        head_size  = q_size[rd_ptr];
        head_wdata = q_wdata[rd_ptr];
        if (count == '0) begin
            head_wr    = data_wr;
            head_wstrb = data_wstrb;
            head_idx   = in_idx;
            head_size  = data_size;
            head_wdata = data_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_wr[wr_ptr]    <= data_wr;
            q_wstrb[wr_ptr] <= data_wstrb;
            q_idx[wr_ptr]   <= in_idx;
            q_size[wr_ptr]  <= data_size;
            q_wdata[wr_ptr] <= data_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            svc_wr    <= head_wr;
            svc_wstrb <= head_wstrb;
            svc_idx   <= head_idx;
            svc_size  <= head_size;
            svc_wdata <= head_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (svc_wstrb[i]) begin
                    mem[svc_idx][8*i +: 8] <= svc_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            lat_cnt      <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            data_data_ok <= 1'b0;
            data_rdata   <= '0;
            data_resp_wr <= 1'b0;
        end else begin
            data_data_ok <= 1'b0;
            count        <= count_next;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        lat_cnt <= LAT_LOAD;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (lat_cnt != '0) begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end else begin
                        data_data_ok <= 1'b1;
                        data_resp_wr <= svc_wr;
                        data_rdata   <= svc_wr ? 32'h0 : mem[svc_idx];
                        if (pop) begin
                            lat_cnt <= LAT_LOAD;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
